token_packer: RTL and testbench
===============================

TOKEN_PACKER -- requirements
Module: token_packer

Interface
REQ-001 SHALL have parameter TOKEN_W, default 11: width of one compressed token (3 offset, 3 length, 5 letter code).
REQ-002 SHALL have parameter WORD_W, default 32: output word width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset; reset==0 forces the reset state immediately.
REQ-005 SHALL have port tok_valid  input  1  upstream token present.
REQ-006 SHALL have port tok_data  input  TOKEN_W  token bits; bit TOKEN_W-1 is packed first.
REQ-007 SHALL have port tok_last  input  1  marks final token of a block; qualified by tok_valid.
REQ-008 SHALL have port tok_ready  output  1  packer can accept a token this cycle.
REQ-009 SHALL have port out_valid  output  1  out_data holds a word.
REQ-010 SHALL have port out_data  output  WORD_W  packed word, MSB-first, zero-padded at LSBs.
REQ-011 SHALL have port out_bits  output  6  count of meaningful bits in out_data (1..WORD_W).
REQ-012 SHALL have port out_last  output  1  final word of the block.
REQ-013 SHALL have port out_ready  input  1  downstream accepts the word.

Function
REQ-014 SHALL hold an accumulator of WORD_W+TOKEN_W bits, a fill count cnt (0..WORD_W+TOKEN_W-1) and a last_seen flag.
REQ-015 SHALL implement states FILL, EMIT, FLUSH.
REQ-016 SHALL assert tok_ready only in FILL; in FILL cnt < WORD_W always holds.
REQ-017 SHALL, on tok_valid&&tok_ready, append tok_data directly below the cnt bits already held, add TOKEN_W to cnt, and set last_seen=tok_last.
REQ-018 SHALL, after an accept, go to EMIT if the new cnt >= WORD_W, else go to FLUSH if tok_last, else stay in FILL.
REQ-019 SHALL in EMIT drive out_valid=1, out_data=top WORD_W accumulator bits, out_bits=WORD_W, and out_last=last_seen&&(cnt==WORD_W).
REQ-020 SHALL on the EMIT handshake (out_valid&&out_ready) shift the accumulator left by WORD_W and subtract WORD_W from cnt, then go to FLUSH if last_seen&&cnt>0 after the shift; otherwise clear last_seen if it was set and go to FILL.
REQ-021 SHALL in FLUSH drive out_valid=1, out_data=remaining cnt bits left-aligned with zeros below, out_bits=cnt, and out_last=1.
REQ-022 SHALL on the FLUSH handshake clear the accumulator, cnt and last_seen, and go to FILL.
REQ-023 SHALL keep out_data, out_bits and out_last stable while out_valid=1 and out_ready=0.
REQ-024 SHALL drive out_valid=0 in FILL, and out_bits/out_last=0 whenever out_valid=0.
REQ-025 SHALL give a latency of one cycle: a token accepted at edge N that completes a word makes out_valid high after edge N.
REQ-026 SHALL sustain a throughput of one token per cycle while out_ready=1, apart from the cycles spent in EMIT/FLUSH.
REQ-027 SHALL pack tokens with no gaps across word boundaries, including tokens that split across two words.
REQ-028 SHALL ignore tok_data and tok_last when tok_valid=0.

Reset
REQ-029 SHALL on reset==0 set the state to FILL, clear the accumulator, cnt and last_seen, and drive tok_ready=0, out_valid=0, out_data=0, out_bits=0, out_last=0.
REQ-030 SHALL drive tok_ready=1 from the first rising edge after reset deasserts.
REQ-031 SHALL, when reset asserts mid-block (in EMIT or FLUSH), discard the partial word with no further out_valid.

Verification
REQ-032 SHALL cover: tokens 0x001, 0x002, 0x003 (last on the third), out_ready=1 -> word 0x00200801 with out_bits=32 and out_last=0, then word 0x80000000 with out_bits=1 and out_last=1.
REQ-033 SHALL cover: a single token 0x7FF with tok_last=1 -> one word 0xFFE00000 with out_bits=11 and out_last=1, one cycle after the accept.
REQ-034 SHALL cover: 32 tokens (352 bits) with the last on the 32nd -> exactly 11 words, all with out_bits=32, out_last only on the 11th, and no FLUSH word.
REQ-035 SHALL cover: out_ready held 0 for 5 cycles during EMIT -> out_data stable, tok_ready=0 throughout, and the word transferred on the first cycle out_ready=1.
REQ-036 SHALL cover: reset pulsed low while in FLUSH -> out_valid falls without waiting for a clock edge, and the next block packs from cnt=0.
REQ-037 SHALL cover: random tokens with random tok_valid/out_ready -> the concatenated output bits (truncated by out_bits) equal the concatenated input tokens.

Source files
------------

// File: rtl/token_packer.sv
// Packs TOKEN_W-bit tokens MSB-first into WORD_W-bit words and flushes a left-aligned partial word at end of block.
// One cycle from the completing accept to out_valid; tok_ready is low while a word waits for out_ready.
module token_packer #(
  parameter int TOKEN_W = 11,
  parameter int WORD_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tok_valid,
  input  logic [TOKEN_W-1:0] tok_data,
  input  logic               tok_last,
  output logic               tok_ready,
  output logic               out_valid,
  output logic [WORD_W-1:0]  out_data,
  output logic [5:0]         out_bits,
  output logic               out_last,
  input  logic               out_ready
);

  localparam int ACC_W = WORD_W + TOKEN_W;
  localparam int CNT_W = $clog2(ACC_W);

  typedef enum logic [1:0] {S_FILL, S_EMIT, S_FLUSH} state_t;

  state_t             r_state, w_state_nxt;
  logic [ACC_W-1:0]   r_acc, w_acc_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_last_seen, w_last_nxt;
  logic               r_live;

  logic               w_tok_fire;
  logic [ACC_W-1:0]   w_tok_ext;
  logic [CNT_W-1:0]   w_cnt_add;
  logic [CNT_W-1:0]   w_cnt_sub;

  // Accumulator is left-aligned: held bits occupy the top r_cnt positions, the rest are zero.
  assign w_tok_fire = tok_valid && tok_ready;
  assign w_tok_ext  = {tok_data, {WORD_W{1'b0}}};
  assign w_cnt_add  = r_cnt + CNT_W'(TOKEN_W);
  assign w_cnt_sub  = r_cnt - CNT_W'(WORD_W);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_FILL;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_last_seen <= 1'b0;
      r_live      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_last_seen <= w_last_nxt;
      r_live      <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last_seen;
    case (r_state)
      S_FILL: begin
        if (w_tok_fire) begin
          w_acc_nxt  = r_acc | (w_tok_ext >> r_cnt);
          w_cnt_nxt  = w_cnt_add;
          w_last_nxt = tok_last;
          if (w_cnt_add >= CNT_W'(WORD_W)) begin
            w_state_nxt = S_EMIT;
          end else if (tok_last) begin
            w_state_nxt = S_FLUSH;
          end
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          w_acc_nxt = r_acc << WORD_W;
          w_cnt_nxt = w_cnt_sub;
          if (r_last_seen && (w_cnt_sub != '0)) begin
            w_state_nxt = S_FLUSH;
          end else begin
            w_last_nxt  = 1'b0;
            w_state_nxt = S_FILL;
          end
        end
      end
      S_FLUSH: begin
        if (out_ready) begin
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_last_nxt  = 1'b0;
          w_state_nxt = S_FILL;
        end
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  // Outputs decode from registered state only, so they hold steady under backpressure.
  always_comb begin
    tok_ready = r_live && (r_state == S_FILL);
    out_valid = 1'b0;
    out_data  = '0;
    out_bits  = '0;
    out_last  = 1'b0;
    case (r_state)
      S_EMIT: begin
        out_valid = 1'b1;
        out_data  = r_acc[ACC_W-1 -: WORD_W];
        out_bits  = 6'(WORD_W);
        out_last  = r_last_seen && (r_cnt == CNT_W'(WORD_W));
      end
      S_FLUSH: begin
        out_valid = 1'b1;
        out_data  = r_acc[ACC_W-1 -: WORD_W];
        out_bits  = 6'(r_cnt);
        out_last  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_token_packer.sv
module tb_token_packer;
  localparam int TW = 11;
  localparam int WW = 32;

  logic          clk;
  logic          reset;
  logic          tok_valid;
  logic [TW-1:0] tok_data;
  logic          tok_last;
  logic          tok_ready;
  logic          out_valid;
  logic [WW-1:0] out_data;
  logic [5:0]    out_bits;
  logic          out_last;
  logic          out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  logic [WW-1:0] q_data[$];
  logic [5:0]    q_bits[$];
  logic          q_last[$];
  bit            in_q[$];
  bit            out_q[$];
  int            n_last_in = 0;
  int            n_last_out = 0;

  token_packer #(.TOKEN_W(TW), .WORD_W(WW)) dut (
    .clk(clk), .reset(reset),
    .tok_valid(tok_valid), .tok_data(tok_data), .tok_last(tok_last), .tok_ready(tok_ready),
    .out_valid(out_valid), .out_data(out_data), .out_bits(out_bits), .out_last(out_last),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshakes are observed mid-cycle, where inputs and outputs are both settled.
  always @(negedge clk) begin
    if (reset && tok_valid && tok_ready) begin
      for (int k = TW - 1; k >= 0; k--) in_q.push_back(tok_data[k]);
      if (tok_last) n_last_in++;
    end
    if (reset && out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_bits.push_back(out_bits);
      q_last.push_back(out_last);
      for (int k = 0; k < int'(out_bits); k++) out_q.push_back(out_data[WW-1-k]);
      if (out_last) n_last_out++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Holds the token until accepted; returns at 1 time unit after the accepting edge.
  task automatic send_tok(input logic [TW-1:0] d, input logic l);
    bit done = 0;
    int t = 0;
    tok_valid = 1'b1; tok_data = d; tok_last = l;
    while (!done && t < 60) begin
      @(negedge clk);
      if (tok_ready) done = 1;
      @(posedge clk); #1;
      t++;
    end
    tok_valid = 1'b0; tok_last = 1'b0;
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL send_tok: token %h not accepted, got timeout after %0d cycles, required accept", d, t);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; tok_valid = 1'b0; tok_data = '0; tok_last = 1'b0; out_ready = 1'b0;
    #3;
    n_cmp++; if (tok_ready !== 1'b0) begin n_bad++; $display("FAIL rst_tok_ready: got %b required 0", tok_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL rst_out_data: got %h required 0", out_data); end
    n_cmp++; if (out_bits !== 6'd0) begin n_bad++; $display("FAIL rst_out_bits: got %0d required 0", out_bits); end
    n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL rst_out_last: got %b required 0", out_last); end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_cmp++; if (tok_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready_pre_edge: got %b required 0", tok_ready); end
    @(posedge clk); #1;
    n_cmp++; if (tok_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready_post_edge: got %b required 1", tok_ready); end
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    send_tok(11'h001, 1'b0);
    send_tok(11'h002, 1'b0);
    send_tok(11'h003, 1'b1);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_w0_valid: got %b required 1", out_valid); end
    n_cmp++; if (out_data !== 32'h00200801) begin n_bad++; $display("FAIL basic_w0_data: got %h required 00200801", out_data); end
    n_cmp++; if (out_bits !== 6'd32) begin n_bad++; $display("FAIL basic_w0_bits: got %0d required 32", out_bits); end
    n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL basic_w0_last: got %b required 0", out_last); end
    idle(1);
    n_cmp++; if (out_data !== 32'h80000000) begin n_bad++; $display("FAIL basic_w1_data: got %h required 80000000", out_data); end
    n_cmp++; if (out_bits !== 6'd1) begin n_bad++; $display("FAIL basic_w1_bits: got %0d required 1", out_bits); end
    n_cmp++; if (out_last !== 1'b1) begin n_bad++; $display("FAIL basic_w1_last: got %b required 1", out_last); end
    idle(1);
    n_cmp++; if (out_valid !== 1'b0 || tok_ready !== 1'b1) begin n_bad++; $display("FAIL basic_idle: got valid=%b ready=%b required 0/1", out_valid, tok_ready); end
  endtask

  task automatic test_single;
    out_ready = 1'b1;
    send_tok(11'h7FF, 1'b1);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_latency: got valid=%b required 1", out_valid); end
    n_cmp++; if (out_data !== 32'hFFE00000) begin n_bad++; $display("FAIL single_data: got %h required ffe00000", out_data); end
    n_cmp++; if (out_bits !== 6'd11 || out_last !== 1'b1) begin n_bad++; $display("FAIL single_bits_last: got %0d/%b required 11/1", out_bits, out_last); end
    n_cmp++; if (tok_ready !== 1'b0) begin n_bad++; $display("FAIL single_ready_low: got %b required 0", tok_ready); end
    idle(1);
    n_cmp++; if (out_valid !== 1'b0 || out_bits !== 6'd0 || out_last !== 1'b0) begin
      n_bad++; $display("FAIL single_after: got valid=%b bits=%0d last=%b required 0/0/0", out_valid, out_bits, out_last);
    end
  endtask

  task automatic test_full_block;
    int base;
    base = q_data.size();
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) send_tok((i % 2 == 0) ? 11'h555 : 11'h2AA, i == 31);
    idle(4);
    n_cmp++; if (q_data.size() - base !== 11) begin n_bad++; $display("FAIL full_word_count: got %0d required 11", q_data.size() - base); end
    if (q_data.size() - base == 11) begin
      for (int i = 0; i < 11; i++) begin
        n_cmp++; if (q_data[base+i] !== 32'hAAAAAAAA) begin n_bad++; $display("FAIL full_data[%0d]: got %h required aaaaaaaa", i, q_data[base+i]); end
        n_cmp++; if (q_bits[base+i] !== 6'd32) begin n_bad++; $display("FAIL full_bits[%0d]: got %0d required 32", i, q_bits[base+i]); end
        n_cmp++; if (q_last[base+i] !== (i == 10)) begin n_bad++; $display("FAIL full_last[%0d]: got %b required %b", i, q_last[base+i], i == 10); end
      end
    end
  endtask

  task automatic test_stall;
    int base;
    out_ready = 1'b0;
    send_tok(11'h001, 1'b0);
    send_tok(11'h002, 1'b0);
    send_tok(11'h003, 1'b0);
    base = q_data.size();
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h00200801 || tok_ready !== 1'b0) begin
        n_bad++; $display("FAIL stall_hold[%0d]: got valid=%b data=%h ready=%b required 1/00200801/0", c, out_valid, out_data, tok_ready);
      end
      idle(1);
    end
    out_ready = 1'b1;
    idle(1);
    n_cmp++; if (q_data.size() !== base + 1) begin n_bad++; $display("FAIL stall_transfer: got %0d words required %0d", q_data.size(), base + 1); end
    n_cmp++; if (out_valid !== 1'b0 || tok_ready !== 1'b1) begin n_bad++; $display("FAIL stall_resume: got valid=%b ready=%b required 0/1", out_valid, tok_ready); end
    send_tok(11'h000, 1'b1);
    n_cmp++; if (out_data !== 32'h80000000 || out_bits !== 6'd12 || out_last !== 1'b1) begin
      n_bad++; $display("FAIL stall_flush: got %h/%0d/%b required 80000000/12/1", out_data, out_bits, out_last);
    end
    idle(2);
  endtask

  task automatic test_reset_in_flush;
    int base;
    out_ready = 1'b0;
    send_tok(11'h123, 1'b1);
    n_cmp++; if (out_valid !== 1'b1 || out_bits !== 6'd11) begin n_bad++; $display("FAIL rflush_pre: got valid=%b bits=%0d required 1/11", out_valid, out_bits); end
    base = q_data.size();
    #3 reset = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_bits !== 6'd0 || tok_ready !== 1'b0) begin
      n_bad++; $display("FAIL rflush_async: got valid=%b bits=%0d ready=%b required 0/0/0", out_valid, out_bits, tok_ready);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    out_ready = 1'b1;
    send_tok(11'h7FF, 1'b1);
    n_cmp++; if (out_data !== 32'hFFE00000 || out_bits !== 6'd11 || out_last !== 1'b1) begin
      n_bad++; $display("FAIL rflush_next: got %h/%0d/%b required ffe00000/11/1", out_data, out_bits, out_last);
    end
    idle(2);
    n_cmp++; if (q_data.size() !== base + 1) begin n_bad++; $display("FAIL rflush_discard: got %0d words required %0d", q_data.size(), base + 1); end
  endtask

  task automatic test_random;
    int last_in0, last_out0, bad_idx;
    in_q.delete();
    out_q.delete();
    last_in0 = n_last_in;
    last_out0 = n_last_out;
    for (int c = 0; c < 400; c++) begin
      tok_valid = ($urandom_range(0, 3) != 0);
      tok_data  = TW'($urandom);
      tok_last  = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      idle(1);
    end
    tok_valid = 1'b0; tok_last = 1'b0;
    out_ready = 1'b1;
    idle(3);
    send_tok(11'h5A3, 1'b1);
    idle(4);
    bad_idx = -1;
    n_cmp++; if (out_q.size() !== in_q.size()) begin
      n_bad++; $display("FAIL rand_len: got %0d bits required %0d", out_q.size(), in_q.size());
    end else begin
      for (int i = 0; i < in_q.size(); i++) if (bad_idx < 0 && out_q[i] !== in_q[i]) bad_idx = i;
    end
    n_cmp++; if (bad_idx !== -1) begin n_bad++; $display("FAIL rand_stream: got first differing bit at %0d required none", bad_idx); end
    n_cmp++; if (n_last_out - last_out0 !== n_last_in - last_in0) begin
      n_bad++; $display("FAIL rand_last_count: got %0d required %0d", n_last_out - last_out0, n_last_in - last_in0);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_single;
    test_full_block;
    test_stall;
    test_reset_in_flush;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
